// File: rtl/push_button_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner.
//   btn_state_t : per-channel debounce FSM state
//   cnt_width() : width that holds the largest of the three timing constants without wrapping
package push_button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  function automatic int unsigned cnt_width(input int unsigned debounce_cycles,
                                            input int unsigned repeat_delay,
                                            input int unsigned repeat_rate);
    int unsigned m;
    m = debounce_cycles;
    if (repeat_delay > m) m = repeat_delay;
    if (repeat_rate > m) m = repeat_rate;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/push_button_conditioner_if.sv
// Board-side bundle of the push-button conditioner.
//   btn_up_raw / btn_dn_raw     : raw, bouncy, asynchronous buttons (1 = pressed)
//   push1 / push2               : one-cycle up/down strobes towards the counter
//   btn_up_level / btn_dn_level : debounced button levels
// master drives the raw buttons and observes the outputs; slave is the conditioner.
interface push_button_conditioner_if;

  logic btn_up_raw;
  logic btn_dn_raw;
  logic push1;
  logic push2;
  logic btn_up_level;
  logic btn_dn_level;

  modport master (
    output btn_up_raw,
    output btn_dn_raw,
    input  push1,
    input  push2,
    input  btn_up_level,
    input  btn_dn_level
  );

  modport slave (
    input  btn_up_raw,
    input  btn_dn_raw,
    output push1,
    output push2,
    output btn_up_level,
    output btn_dn_level
  );

endinterface

// File: rtl/push_button_conditioner_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM, saturating counters, one-shot strobe
// and optional hold-to-auto-repeat.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   raw_i    : raw button (asynchronous, bouncy)
//   strobe_o : registered single-cycle strobe (press accepted, or auto-repeat tick)
//   level_o  : registered debounced level
module button_channel
  import push_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_RATE     = 5_000_000,
  parameter int unsigned CntW            = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic strobe_o,
  output logic level_o
);

  // Counters compare against "last" values: the transition happens on the edge at which the
  // N-th qualifying sample is seen, so the count before that edge is N-1.
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] CntMax    = {CntW{1'b1}};
  localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  logic            sync1_q, sync2_q;
  btn_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] rpt_q, rpt_d;
  logic            rpt_rate_q, rpt_rate_d;  // first repeat done, now pacing at REPEAT_RATE
  logic            level_q, level_d;
  logic            strobe_q, strobe_d;
  logic            fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rpt_q      <= '0;
      rpt_rate_q <= 1'b0;
      level_q    <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rpt_q      <= rpt_d;
      rpt_rate_q <= rpt_rate_d;
      level_q    <= level_d;
      strobe_q   <= strobe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rpt_d      = rpt_q;
    rpt_rate_d = rpt_rate_q;
    level_d    = level_q;
    fire       = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CntOne;
        end
      end

      PRESS_WAIT: begin
        if (!sync2_q) begin
          // Bounce: start qualification over.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d    = HELD;
          level_d    = 1'b1;
          fire       = 1'b1;
          cnt_d      = '0;
          rpt_d      = '0;
          rpt_rate_d = 1'b0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CntOne;
        end else if (REPEAT_EN) begin
          if (rpt_q == (rpt_rate_q ? RateLast : DelayLast)) begin
            fire       = 1'b1;
            rpt_d      = '0;
            rpt_rate_d = 1'b1;
          end else begin
            rpt_d = sat_inc(rpt_q);
          end
        end
      end

      RELEASE_WAIT: begin
        if (sync2_q) begin
          // Release glitch: back to HELD without a strobe, repeat timing starts over.
          state_d    = HELD;
          cnt_d      = '0;
          rpt_d      = '0;
          rpt_rate_d = 1'b0;
        end else if (cnt_q == DebLast) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Suppress a strobe that would sit directly behind another (e.g. REPEAT_DELAY of 1).
    strobe_d = fire & ~strobe_q;
  end

  assign strobe_o = strobe_q;
  assign level_o  = level_q;

endmodule

// File: rtl/push_button_conditioner.sv
// Push-button conditioner: two debounced channels (up, down) feeding a single-cycle strobe
// arbiter so the downstream counter never sees push1 and push2 together.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_io : slave side of push_button_conditioner_if (raw buttons in; strobes and levels out)
module push_button_conditioner
  import push_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_RATE     = 5_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  push_button_conditioner_if.slave     bus_io
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

  logic up_strobe, dn_strobe;
  logic up_level, dn_level;
  logic dn_req;
  logic pend_q, pend_d;

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE),
    .CntW            (CntW)
  ) u_up (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (bus_io.btn_up_raw),
    .strobe_o (up_strobe),
    .level_o  (up_level)
  );

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE),
    .CntW            (CntW)
  ) u_dn (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (bus_io.btn_dn_raw),
    .strobe_o (dn_strobe),
    .level_o  (dn_level)
  );

  // push1 always wins; a down request that collides with it waits one cycle in pend_q.
  // Reset clears pend_q, so a deferred push2 is lost on reset.
  always_comb begin
    dn_req = dn_strobe | pend_q;
    pend_d = dn_req & up_strobe;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign bus_io.push1        = up_strobe;
  assign bus_io.push2        = dn_req & ~up_strobe;
  assign bus_io.btn_up_level = up_level;
  assign bus_io.btn_dn_level = dn_level;

endmodule

// File: tb/tb_push_button_conditioner.sv
// Two conditioners (REPEAT_EN=0 as inst0, REPEAT_EN=1 as inst1) share the same raw buttons.
// Expected strobe cycles go into a queue when the buttons are driven; a negedge monitor pops
// and compares them whenever a strobe appears.
module tb_push_button_conditioner;

  localparam int Deb  = 4;
  localparam int Dly  = 20;
  localparam int Rate = 8;
  localparam int Lat  = Deb + 2;  // raw change driven at cycle c -> strobe seen at c+Lat

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  push_button_conditioner_if bus0 ();
  push_button_conditioner_if bus1 ();

  push_button_conditioner #(
    .DEBOUNCE_CYCLES (Deb),
    .REPEAT_EN       (1'b0),
    .REPEAT_DELAY    (Dly),
    .REPEAT_RATE     (Rate)
  ) u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus0)
  );

  push_button_conditioner #(
    .DEBOUNCE_CYCLES (Deb),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY    (Dly),
    .REPEAT_RATE     (Rate)
  ) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus1)
  );

  // idx = inst*2 + ch, ch 0 = up/push1, ch 1 = down/push2
  typedef struct {
    int idx;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   both_high = 0;

  typedef struct {
    logic up;
    logic dn;
    int   hold;
    int   up_off;   // 0 = no up strobe expected from this row
    int   dn_off;
    logic lvl_up;
    logic lvl_dn;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
  endtask

  function automatic string idx_name(input int idx);
    return $sformatf("inst%0d.push%0d", idx / 2, (idx % 2) + 1);
  endfunction

  task automatic expect_at(input int idx, input int at);
    exp_q.push_back('{idx: idx, at: at});
  endtask

  // Press on channel ch qualifying at cycle h, raw released at cycle r.
  // inst1 repeats while the FSM still samples the button high (up to r+2).
  task automatic expect_hold(input int ch, input int h, input int r);
    int t;
    expect_at(ch, h);
    expect_at(2 + ch, h);
    t = h + Dly;
    while (t <= r + 2) begin
      expect_at(2 + ch, t);
      t += Rate;
    end
  endtask

  task automatic got_strobe(input int idx);
    int hit;
    hit = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (hit < 0 && exp_q[i].idx == idx) hit = i;
    end
    check({idx_name(idx), " strobe expected"}, (hit >= 0) ? 1 : 0, 1);
    if (hit >= 0) begin
      check({idx_name(idx), " strobe cycle"}, cyc, exp_q[hit].at);
      exp_q.delete(hit);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.push1) got_strobe(0);
    if (bus0.push2) got_strobe(1);
    if (bus1.push1) got_strobe(2);
    if (bus1.push2) got_strobe(3);
    if (bus0.push1 && bus0.push2) both_high++;
    if (bus1.push1 && bus1.push2) both_high++;
  end

  task automatic drive(input logic up, input logic dn);
    bus0.btn_up_raw = up;
    bus0.btn_dn_raw = dn;
    bus1.btn_up_raw = up;
    bus1.btn_dn_raw = dn;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_levels(input string tag, input logic up, input logic dn);
    check({tag, " inst0 up level"}, int'(bus0.btn_up_level), int'(up));
    check({tag, " inst0 dn level"}, int'(bus0.btn_dn_level), int'(dn));
    check({tag, " inst1 up level"}, int'(bus1.btn_up_level), int'(up));
    check({tag, " inst1 dn level"}, int'(bus1.btn_dn_level), int'(dn));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " inst0 push1"}, int'(bus0.push1), 0);
    check({tag, " inst0 push2"}, int'(bus0.push2), 0);
    check({tag, " inst1 push1"}, int'(bus1.push1), 0);
    check({tag, " inst1 push2"}, int'(bus1.push2), 0);
    check_levels(tag, 1'b0, 1'b0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, " outstanding strobes"}, exp_q.size(), 0);
  endtask

  initial begin
    int c, g, r, rr;

    //                up    dn    hold up_off  dn_off   lvl_up lvl_dn
    vecs.push_back('{1'b0, 1'b0, 4,   0,      0,       1'b0,  1'b0});  // idle
    vecs.push_back('{1'b1, 1'b0, 1,   0,      0,       1'b0,  1'b0});  // bounce
    vecs.push_back('{1'b0, 1'b0, 1,   0,      0,       1'b0,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 1,   0,      0,       1'b0,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 1,   0,      0,       1'b0,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 5,   Lat,    0,       1'b0,  1'b0});  // settles, not yet accepted
    vecs.push_back('{1'b1, 1'b0, 5,   0,      0,       1'b1,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 5,   0,      0,       1'b1,  1'b0});  // release pending
    vecs.push_back('{1'b0, 1'b0, 5,   0,      0,       1'b0,  1'b0});
    vecs.push_back('{1'b1, 1'b1, 5,   Lat,    Lat + 1, 1'b0,  1'b0});  // simultaneous press
    vecs.push_back('{1'b1, 1'b1, 5,   0,      0,       1'b1,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 5,   0,      0,       1'b1,  1'b1});
    vecs.push_back('{1'b0, 1'b0, 5,   0,      0,       1'b0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, Lat, 0,      Lat,     1'b0,  1'b1});  // level rises exactly at Lat
    vecs.push_back('{1'b0, 1'b0, Lat, 0,      0,       1'b0,  1'b0});  // and falls exactly at Lat

    rst = 1'b0;
    drive(1'b0, 1'b0);
    #1 rst = 1'b1;
    wait_cyc(3);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cyc(2);

    // Table: bounce, level boundaries, simultaneous press, short down press.
    for (int i = 0; i < vecs.size(); i++) begin
      c = cyc;
      drive(vecs[i].up, vecs[i].dn);
      if (vecs[i].up_off != 0) begin
        expect_at(0, c + vecs[i].up_off);
        expect_at(2, c + vecs[i].up_off);
      end
      if (vecs[i].dn_off != 0) begin
        expect_at(1, c + vecs[i].dn_off);
        expect_at(3, c + vecs[i].dn_off);
      end
      wait_cyc(vecs[i].hold);
      check_levels($sformatf("vec%0d", i), vecs[i].lvl_up, vecs[i].lvl_dn);
    end
    wait_cyc(4);
    check_drained("table");

    // Clean press held 40 cycles: one strobe without repeat, three repeats with.
    c = cyc;
    drive(1'b1, 1'b0);
    expect_hold(0, c + Lat, c + 40);
    wait_cyc(20);
    check_levels("clean held", 1'b1, 1'b0);
    wait_cyc(20);
    drive(1'b0, 1'b0);
    wait_cyc(12);
    check_levels("clean released", 1'b0, 1'b0);
    check_drained("clean");

    // Auto-repeat on down: HELD+0, +20, +28, +36, +44, +52, none after release.
    c = cyc;
    drive(1'b0, 1'b1);
    expect_hold(1, c + Lat, c + Lat + 56);
    wait_cyc(Lat + 56);
    drive(1'b0, 1'b0);
    wait_cyc(20);
    check_levels("repeat released", 1'b0, 1'b0);
    check_drained("repeat");

    // Release glitch: 2 low cycles keep the level, 6 low cycles drop it.
    c = cyc;
    drive(1'b1, 1'b0);
    g = c + Lat + 5;
    r = g + 10;
    expect_hold(0, c + Lat, r);
    wait_cyc(g - c);
    drive(1'b0, 1'b0);
    wait_cyc(2);
    drive(1'b1, 1'b0);
    wait_cyc(8);
    check_levels("after glitch", 1'b1, 1'b0);
    drive(1'b0, 1'b0);
    wait_cyc(5);
    check_levels("long low -1", 1'b1, 1'b0);
    wait_cyc(1);
    check_levels("long low", 1'b0, 1'b0);
    wait_cyc(6);
    check_drained("glitch");

    // Reset while a deferred push2 is pending: push2 dropped, full re-qualification after.
    c = cyc;
    drive(1'b1, 1'b1);
    expect_at(0, c + Lat);
    expect_at(2, c + Lat);
    wait_cyc(Lat);
    @(posedge clk);
    #2;
    check("deferred inst0 push2", int'(bus0.push2), 1);
    check("deferred inst1 push2", int'(bus1.push2), 1);
    rst = 1'b1;
    #1;
    check_all_zero("reset pending");
    wait_cyc(3);
    rst = 1'b0;
    rr = cyc;
    expect_at(0, rr + Lat);
    expect_at(2, rr + Lat);
    expect_at(1, rr + Lat + 1);
    expect_at(3, rr + Lat + 1);
    wait_cyc(10);
    drive(1'b0, 1'b0);
    wait_cyc(12);
    check_drained("reset pending");

    // Reset in PRESS_WAIT with the count at 3: nothing fires, then a full 4+2 again.
    c = cyc;
    drive(1'b1, 1'b0);
    wait_cyc(5);
    rst = 1'b1;
    #1;
    check_all_zero("reset mid-press");
    wait_cyc(2);
    rst = 1'b0;
    rr = cyc;
    expect_at(0, rr + Lat);
    expect_at(2, rr + Lat);
    wait_cyc(Lat - 1);
    check_levels("requalify -1", 1'b0, 1'b0);
    wait_cyc(1);
    check_levels("requalify", 1'b1, 1'b0);
    wait_cyc(4);
    drive(1'b0, 1'b0);
    wait_cyc(12);
    check_drained("reset mid-press");

    check("push1 and push2 never together", both_high, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
